cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Eight-phase instruction-cycle sequencer for the 5-bit-address RISC CPU.
- Steps a phase counter and decodes the 3-bit opcode from the instruction register into strobes for the address mux, memory, IR, program counter, accumulator and data bus.
- Drives `inc_pc`, `ld_pc` and `halt` of the program counter directly.
- Latches a halt condition that freezes the whole machine until reset.

Parameters:
- NPHASE, 8, phases per instruction cycle; fixed, 3-bit phase counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- opcode  in  3  IR[7:5]: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP
- zero  in  1  accumulator == 0 flag from ALU
- sel  out  1  address mux: 1 = PC address, 0 = IR operand address
- rd  out  1  memory read enable
- ld_ir  out  1  instruction register load
- inc_pc  out  1  PC increment request
- ld_pc  out  1  PC load request (load value = IR[4:0])
- halt  out  1  machine halted; to PC halt input
- data_e  out  1  accumulator drives data bus
- ld_ac  out  1  accumulator load
- wr  out  1  memory write enable
- phase  out  3  current phase, debug/observability

Behaviour:
- Reset is `rst`, synchronous, active-high; clock is `clk`. On reset: `phase` = 0 and `halted` = 0.
- Reset values of all outputs: `sel`=1, all other strobes 0, `halt`=0.
- Phase counter:
  - `phase` increments by 1 every clk while not halted.
  - 7 wraps to 0; no idle cycles between instructions.
- Halted state:
  - At phase 4 with `opcode`=HLT, `halted` sets on that clock edge.
  - `phase` then stays at 5.
  - `halt`=1 combinationally during phase 4 itself and continuously while `halted`.
  - While halted, all strobes other than `halt` are 0, including `sel`.
  - Only `rst` clears `halted`.
- Strobes are combinational from `phase`, `opcode` and `zero`. Define ALUOP = ADD|AND|XOR|LDA.
  - Phase 0 INST_ADDR: `sel`.
  - Phase 1 INST_FETCH: `sel`, `rd`.
  - Phase 2 INST_LOAD: `sel`, `rd`, `ld_ir`.
  - Phase 3 IDLE: `sel`, `rd`, `ld_ir`.
  - Phase 4 OP_ADDR: `inc_pc` = !HLT; `halt` = HLT.
  - Phase 5 OP_FETCH: `rd` = ALUOP.
  - Phase 6 ALU_OP: `rd` = ALUOP; `inc_pc` = SKZ & `zero`; `ld_pc` = JMP; `data_e` = STO.
  - Phase 7 STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = JMP; `wr` = STO; `data_e` = STO.
- Exclusivity:
  - `inc_pc` and `ld_pc` are never high in the same cycle.
  - `wr` is never high with `rd`.
  - `ld_ac` is only high in phase 7.
- Opcode timing:
  - `opcode` is assumed stable from phase 3 onward; it is ignored in phases 0–3.
  - `zero` is sampled only in phase 6.
- Per-instruction PC effects:
  - JMP: `ld_pc` is asserted for two cycles; the PC loads the same value twice, which is intended.
  - SKZ with `zero`=1: PC advances by 2 over the instruction cycle.
  - SKZ with `zero`=0: PC advances by 1.
- Reset mid-cycle (any phase, including halted): next cycle is phase 0 with reset output values. No partial strobes are emitted in the reset cycle beyond those of phase 0.

Test Plan:
- Reset then 8 clocks, `opcode`=ADD: `phase` 0..7 and back to 0. `sel`=1 in phases 0–3; `ld_ir`=1 in phases 2–3; `inc_pc`=1 only in phase 4; `rd`=1 in phases 1,2,3,5,6,7; `ld_ac`=1 only in phase 7.
- `opcode`=STO: `data_e`=1 in phases 6–7; `wr`=1 only in phase 7; `rd`=0 in phases 5–7; `ld_ac` never asserted.
- `opcode`=JMP with PC model loaded from IR[4:0]=5'h13: `ld_pc`=1 in phases 6–7, `inc_pc`=0 in phase 6; PC=0x13 at the next phase 0.
- `opcode`=SKZ: `zero`=1 gives `inc_pc` in phases 4 and 6 and PC +2 per cycle; `zero`=0 gives PC +1.
- `opcode`=HLT at phase 4: `halt`=1, `inc_pc`=0. `phase` holds at 5 for 20 clocks with all other strobes 0. `rst` then returns `phase`=0, `halt`=0, `sel`=1.
- `rst` asserted at phase 6 during JMP: next cycle `phase`=0, `ld_pc`=0, `sel`=1.

Source files
------------

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Eight-phase instruction-cycle sequencer for the 5-bit-address
//               RISC CPU. Steps a phase counter and decodes the opcode held in
//               the instruction register into memory, IR, PC, accumulator and
//               data-bus strobes. A HLT opcode freezes the machine until rst.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller #(
    parameter int NPHASE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       halt,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] c_OP_HLT  = 3'd0;
    localparam logic [2:0] c_OP_SKZ  = 3'd1;
    localparam logic [2:0] c_OP_ADD  = 3'd2;
    localparam logic [2:0] c_OP_AND  = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_LDA  = 3'd5;
    localparam logic [2:0] c_OP_STO  = 3'd6;
    localparam logic [2:0] c_OP_JMP  = 3'd7;
    localparam logic [2:0] c_PH_LAST = 3'(NPHASE - 1);

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;

    // Decode view of the state: while rst is held the strobes already look
    // like phase 0 so no partial strobes from an interrupted phase escape.
    phase_t w_dec_phase;
    logic   w_dec_halted;
    logic   w_is_hlt;
    logic   w_is_skz;
    logic   w_is_sto;
    logic   w_is_jmp;
    logic   w_is_aluop;

    assign w_dec_phase  = rst ? PH_INST_ADDR : r_phase;
    assign w_dec_halted = r_halted & ~rst;
    assign w_is_hlt     = (opcode == c_OP_HLT);
    assign w_is_skz     = (opcode == c_OP_SKZ);
    assign w_is_sto     = (opcode == c_OP_STO);
    assign w_is_jmp     = (opcode == c_OP_JMP);
    assign w_is_aluop   = (opcode == c_OP_ADD) | (opcode == c_OP_AND) |
                          (opcode == c_OP_XOR) | (opcode == c_OP_LDA);
    assign phase        = r_phase;

    // State register: phase counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next state: free-running wrap through all phases, frozen once halted.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (!r_halted) begin
            if (r_phase == c_PH_LAST) begin
                w_phase_nxt = PH_INST_ADDR;
            end else begin
                w_phase_nxt = phase_t'(r_phase + 3'd1);
            end
            if ((r_phase == PH_OP_ADDR) && w_is_hlt) begin
                w_halted_nxt = 1'b1;
            end
        end
    end

    // Strobe decode from phase, opcode and zero flag.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (w_dec_halted) begin
            halt = 1'b1;
        end else begin
            case (w_dec_phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = ~w_is_hlt;
                    halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = w_is_aluop;
                end
                PH_ALU_OP: begin
                    rd     = w_is_aluop;
                    inc_pc = w_is_skz & zero;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                PH_STORE: begin
                    rd     = w_is_aluop;
                    ld_ac  = w_is_aluop;
                    ld_pc  = w_is_jmp;
                    wr     = w_is_sto;
                    data_e = w_is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Directed instruction
//               cycles followed by randomized opcodes, zero flags and resets,
//               checked against an instruction-level reference model and a
//               program-counter model driven by the controller's strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
    logic [2:0] phase;

    cpu_controller #(.NPHASE(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int       m_phase  = 0;
    bit       m_halted = 0;
    int       halt_cnt = 0;
    bit [4:0] pc       = 5'd0;
    bit [4:0] ir_addr  = 5'd0;
    bit [4:0] pc_start = 5'd0;
    bit [2:0] op_rec   = 3'd0;
    bit       z6       = 0;
    bit       cyc_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (phase %0d, t=%0t)", tag, got, exp, m_phase, $time);
        end
    endtask

    // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,halt,data_e,ld_ac,wr}
    function automatic logic [8:0] exp_out(input int ph, input bit hlt, input bit [2:0] op, input bit z);
        bit s = 0, r = 0, li = 0, ip = 0, lp = 0, h = 0, de = 0, la = 0, w = 0;
        bit alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        if (hlt) begin
            h = 1;
        end else if (ph == 0) begin
            s = 1;
        end else if (ph == 1) begin
            s = 1; r = 1;
        end else if (ph == 2 || ph == 3) begin
            s = 1; r = 1; li = 1;
        end else if (ph == 4) begin
            ip = (op != 3'd0); h = (op == 3'd0);
        end else if (ph == 5) begin
            r = alu;
        end else if (ph == 6) begin
            r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6);
        end else begin
            r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); de = (op == 3'd6);
        end
        return {s, r, li, ip, lp, h, de, la, w};
    endfunction

    // One clock of stimulus: drive inputs at negedge, check mid-low-phase,
    // then advance the reference model to the state after the next posedge.
    task automatic step(input bit r, input bit [2:0] op, input bit z, input bit [4:0] addr);
        logic [4:0] exp_pc;
        @(negedge clk);
        rst = r; opcode = op; zero = z;
        #1;
        check("phase", {29'd0, phase}, m_phase);
        if (!r) begin
            check("strobes", {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr},
                  {23'd0, exp_out(m_phase, m_halted, op, z)});
            if (m_phase == 0 && !m_halted) begin
                if (cyc_valid) begin
                    if (op_rec == 3'd7)
                        exp_pc = ir_addr;
                    else if (op_rec == 3'd1 && z6)
                        exp_pc = pc_start + 5'd2;
                    else
                        exp_pc = pc_start + 5'd1;
                    check("pc", {27'd0, pc}, {27'd0, exp_pc});
                end
                pc_start  = pc;
                ir_addr   = addr;
                cyc_valid = 1;
            end
            if (m_phase == 4) op_rec = op;
            if (m_phase == 6) z6 = z;
            if (!halt) begin
                if (ld_pc) pc = ir_addr;
                else if (inc_pc) pc = pc + 5'd1;
            end
        end
        if (r) begin
            m_phase = 0; m_halted = 0; cyc_valid = 0; halt_cnt = 0;
        end else if (m_halted) begin
            halt_cnt++;
        end else begin
            if (m_phase == 4 && op == 3'd0) m_halted = 1;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic run_instr(input bit [2:0] op, input bit z, input bit [4:0] addr);
        for (int i = 0; i < 8; i++) step(0, op, z, addr);
    endtask

    initial begin
        bit [2:0] cur_op;
        bit       do_rst;
        repeat (2) @(posedge clk);
        m_phase = 0; m_halted = 0;
        step(1, 3'd2, 0, 5'd0);
        // Directed instruction cycles
        run_instr(3'd2, 0, 5'd4);      // ADD
        run_instr(3'd6, 0, 5'd9);      // STO
        run_instr(3'd7, 0, 5'h13);     // JMP to 0x13
        run_instr(3'd1, 1, 5'd0);      // SKZ, zero set
        run_instr(3'd1, 0, 5'd0);      // SKZ, zero clear
        run_instr(3'd4, 1, 5'd2);      // XOR
        // HLT: phases 0..4, then 20 halted clocks, then reset
        for (int i = 0; i < 5; i++) step(0, 3'd0, 0, 5'd1);
        for (int i = 0; i < 20; i++) step(0, 3'($urandom_range(0, 7)), 1'($urandom), 5'd1);
        step(1, 3'd0, 0, 5'd0);
        step(0, 3'd5, 0, 5'd3);
        for (int i = 0; i < 7; i++) step(0, 3'd5, 0, 5'd3);
        // Reset at phase 6 of a JMP
        for (int i = 0; i < 6; i++) step(0, 3'd7, 0, 5'h1c);
        step(1, 3'd7, 0, 5'h1c);
        run_instr(3'd3, 0, 5'd7);
        // Randomized run
        cur_op = 3'd2;
        for (int i = 0; i < 2000; i++) begin
            if (m_phase == 0 && !m_halted)
                cur_op = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            do_rst = ($urandom_range(0, 99) == 0) || (m_halted && halt_cnt >= 20);
            step(do_rst, cur_op, 1'($urandom), 5'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
